ras_ctrl: RTL and testbench

Front-end control stage sitting directly upstream of the return address stack (RAS). It pre-decodes each accepted fetch-stage instruction for RISC-V call/return hints and drives the RAS `push`/`pop`/`din` controls. It translates branch-resolution events into the RAS speculation controls `branch`/`close_valid`/`close_invalid`, and tracks the outstanding-branch count so the RAS branch FIFO never overflows. It also returns the RAS prediction (`dout`) to fetch as a registered return-target prediction.

---
 rtl/ras_ctrl.sv | 157 +++++++++++++++
 tb/tb_ras_ctrl.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ras_ctrl.sv
// ras_ctrl: control stage in front of the return address stack.
//
// Each accepted fetch instruction is pre-decoded for RISC-V call/return hints,
// and the decode drives the RAS push/pop/din controls. Branch resolutions become
// the RAS speculation controls. The block counts outstanding branches so that the
// RAS branch FIFO cannot overflow, and it returns the RAS top-of-stack as a
// registered return prediction.
//
// Ports:
//   clk, reset_n           clock, asynchronous active-low reset
//   in_valid/in_ready      fetch handshake; in_pc / in_instr are the instruction
//   res_valid/mispredict   one resolved conditional branch, oldest first
//   ras_push/pop/din       RAS stack controls
//   ras_branch             new speculative branch opened in the RAS
//   ras_close_valid/inv    oldest speculative branch closed: correct / squashed
//   ras_dout, ras_empty    RAS top-of-stack data (valid the cycle after pop), empty
//   pred_valid/pc/target   return prediction, one cycle after a pop
//   err                    sticky: a resolution arrived with no branch outstanding
module ras_ctrl #(
   parameter int unsigned WIDTH        = 32,
   parameter int unsigned MAX_BRANCHES = 16,
   parameter int unsigned CNT_W        = 5
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_pc,
   input  logic [31:0]      in_instr,
   input  logic             res_valid,
   input  logic             res_mispredict,
   output logic             ras_push,
   output logic             ras_pop,
   output logic             ras_branch,
   output logic             ras_close_valid,
   output logic             ras_close_invalid,
   output logic [WIDTH-1:0] ras_din,
   input  logic [WIDTH-1:0] ras_dout,
   input  logic             ras_empty,
   output logic             pred_valid,
   output logic [WIDTH-1:0] pred_pc,
   output logic [WIDTH-1:0] pred_target,
   output logic             err
);

   localparam logic [6:0]       OpJal    = 7'b1101111;
   localparam logic [6:0]       OpJalr   = 7'b1100111;
   localparam logic [6:0]       OpBranch = 7'b1100011;
   localparam logic [CNT_W-1:0] CntMax   = CNT_W'(MAX_BRANCHES);

   typedef enum logic [0:0] {StRun, StFlush} state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             err_q, err_d;
   logic             pred_valid_q;
   logic [WIDTH-1:0] pred_pc_q;

   logic [6:0] opcode;
   logic [4:0] rd, rs1;
   logic       is_jal, is_jalr, is_br;
   logic       link_rd, link_rs1;
   logic       want_push, want_pop;
   logic       res_live, cnt_nz, accept;
   logic       unused_instr;

   // ---------------- decode ----------------
   assign opcode   = in_instr[6:0];
   assign rd       = in_instr[11:7];
   assign rs1      = in_instr[19:15];
   assign is_jal   = (opcode == OpJal);
   assign is_jalr  = (opcode == OpJalr);
   assign is_br    = (opcode == OpBranch);
   assign link_rd  = (rd == 5'd1) || (rd == 5'd5);
   assign link_rs1 = (rs1 == 5'd1) || (rs1 == 5'd5);

   // A linking JALR whose rs1 equals rd is a plain call, not a coroutine swap.
   assign want_push = (is_jal || is_jalr) && link_rd;
   assign want_pop  = is_jalr && link_rs1 && (!link_rd || (rd != rs1));

   // Immediates and funct3 play no part in the hint decode.
   assign unused_instr = ^{in_instr[31:20], in_instr[14:12]};

   // Resolutions are dropped during the flush cycle.
   assign res_live = res_valid && (state_q == StRun);
   assign cnt_nz   = (cnt_q != '0);

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= StRun;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StRun:   if (ras_close_invalid) state_d = StFlush;
         StFlush: state_d = StRun;
         default: state_d = StRun;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      ras_close_valid   = res_live && !res_mispredict && cnt_nz;
      ras_close_invalid = res_live && res_mispredict && cnt_nz;

      // A branch at the limit is still taken when a close frees a slot this cycle.
      in_ready = (state_q == StRun) && !(res_valid && res_mispredict) &&
                 !(in_valid && is_br && (cnt_q == CntMax) && !ras_close_valid);
      accept   = in_valid && in_ready;

      ras_push   = accept && want_push;
      // An empty stack gives no return target, unless the same cycle pushes one.
      ras_pop    = accept && want_pop && (!ras_empty || ras_push);
      ras_branch = accept && is_br;
      ras_din    = ras_push ? (in_pc + WIDTH'(4)) : '0;
   end

   // ---------------- branch counter and error flag ----------------
   always_comb begin
      cnt_d = cnt_q;
      if (ras_close_invalid) begin
         cnt_d = '0;
      end else if (ras_branch && !ras_close_valid) begin
         cnt_d = cnt_q + CNT_W'(1);
      end else if (!ras_branch && ras_close_valid) begin
         cnt_d = cnt_q - CNT_W'(1);
      end
      err_d = err_q || (res_live && !cnt_nz);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q        <= '0;
         err_q        <= 1'b0;
         pred_valid_q <= 1'b0;
         pred_pc_q    <= '0;
      end else begin
         cnt_q        <= cnt_d;
         err_q        <= err_d;
         pred_valid_q <= ras_pop;
         if (ras_pop) pred_pc_q <= in_pc;
      end
   end

   // RAS read data arrives the cycle after the pop, so the target passes straight through.
   assign pred_valid  = pred_valid_q;
   assign pred_pc     = pred_pc_q;
   assign pred_target = pred_valid_q ? ras_dout : '0;
   assign err         = err_q;

endmodule

// File: tb/tb_ras_ctrl.sv
module tb_ras_ctrl;

   localparam int W = 32;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          in_valid = 1'b0, in_ready;
   logic [W-1:0]  in_pc = '0;
   logic [31:0]   in_instr = 32'h13;
   logic          res_valid = 1'b0, res_mispredict = 1'b0;
   logic          ras_push, ras_pop, ras_branch, ras_close_valid, ras_close_invalid;
   logic [W-1:0]  ras_din, ras_dout = '0;
   logic          ras_empty = 1'b0;
   logic          pred_valid, err;
   logic [W-1:0]  pred_pc, pred_target;

   int n_cmp = 0;
   int n_bad = 0;

   ras_ctrl #(.WIDTH(W), .MAX_BRANCHES(16), .CNT_W(5)) dut (
      .clk(clk), .reset_n(reset_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_instr(in_instr),
      .res_valid(res_valid), .res_mispredict(res_mispredict),
      .ras_push(ras_push), .ras_pop(ras_pop), .ras_branch(ras_branch),
      .ras_close_valid(ras_close_valid), .ras_close_invalid(ras_close_invalid),
      .ras_din(ras_din), .ras_dout(ras_dout), .ras_empty(ras_empty),
      .pred_valid(pred_valid), .pred_pc(pred_pc), .pred_target(pred_target), .err(err)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] enc_jal(input logic [4:0] rd);
      return {20'h0, rd, 7'b1101111};
   endfunction
   function automatic logic [31:0] enc_jalr(input logic [4:0] rd, input logic [4:0] rs1);
      return {12'h0, rs1, 3'b000, rd, 7'b1100111};
   endfunction
   function automatic logic [31:0] enc_br();
      return {7'h0, 5'd3, 5'd2, 3'b000, 5'h0, 7'b1100011};
   endfunction

   task automatic drive(input logic v, input logic [W-1:0] pc, input logic [31:0] ins,
                        input logic rv, input logic rm, input logic emp, input logic [W-1:0] dout);
      in_valid = v; in_pc = pc; in_instr = ins;
      res_valid = rv; res_mispredict = rm; ras_empty = emp; ras_dout = dout;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      drive(1'b0, '0, 32'h13, 1'b0, 1'b0, 1'b0, '0);
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      drive(1'b0, 32'h40, 32'h13, 1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF);
      @(negedge clk);
      n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b want 1", in_ready); end
      n_cmp++; if ({ras_push, ras_pop, ras_branch, ras_close_valid, ras_close_invalid} !== 5'b0) begin
         n_bad++; $display("FAIL reset_ras_ctl: got %b want 00000",
                           {ras_push, ras_pop, ras_branch, ras_close_valid, ras_close_invalid}); end
      n_cmp++; if (ras_din !== '0) begin n_bad++; $display("FAIL reset_din: got %h want 0", ras_din); end
      n_cmp++; if ({pred_valid, err} !== 2'b00) begin n_bad++; $display("FAIL reset_flags: got %b want 00", {pred_valid, err}); end
      n_cmp++; if (pred_pc !== '0 || pred_target !== '0) begin
         n_bad++; $display("FAIL reset_pred: got pc %h tgt %h want 0 0", pred_pc, pred_target); end
      tick();
   endtask

   task automatic test_call_return();
      do_reset();
      drive(1'b1, 32'h100, enc_jal(5'd1), 1'b0, 1'b0, 1'b1, '0);
      @(negedge clk);
      n_cmp++; if ({ras_push, ras_pop} !== 2'b10) begin n_bad++; $display("FAIL call_pushpop: got %b want 10", {ras_push, ras_pop}); end
      n_cmp++; if (ras_din !== 32'h104) begin n_bad++; $display("FAIL call_din: got %h want 104", ras_din); end
      tick();
      drive(1'b1, 32'h200, enc_jalr(5'd0, 5'd1), 1'b0, 1'b0, 1'b0, '0);
      @(negedge clk);
      n_cmp++; if ({ras_push, ras_pop} !== 2'b01) begin n_bad++; $display("FAIL ret_pushpop: got %b want 01", {ras_push, ras_pop}); end
      tick();
      drive(1'b0, '0, 32'h13, 1'b0, 1'b0, 1'b1, 32'h104);
      @(negedge clk);
      n_cmp++; if (pred_valid !== 1'b1) begin n_bad++; $display("FAIL ret_pred_valid: got %b want 1", pred_valid); end
      n_cmp++; if (pred_pc !== 32'h200) begin n_bad++; $display("FAIL ret_pred_pc: got %h want 200", pred_pc); end
      n_cmp++; if (pred_target !== 32'h104) begin n_bad++; $display("FAIL ret_pred_tgt: got %h want 104", pred_target); end
      tick();
      @(negedge clk);
      n_cmp++; if (pred_valid !== 1'b0) begin n_bad++; $display("FAIL ret_pred_drop: got %b want 0", pred_valid); end
      tick();
   endtask

   task automatic test_coroutine();
      do_reset();
      drive(1'b1, 32'h300, enc_jalr(5'd1, 5'd5), 1'b0, 1'b0, 1'b0, '0);
      @(negedge clk);
      n_cmp++; if ({ras_push, ras_pop} !== 2'b11) begin n_bad++; $display("FAIL co_pushpop: got %b want 11", {ras_push, ras_pop}); end
      n_cmp++; if (ras_din !== 32'h304) begin n_bad++; $display("FAIL co_din: got %h want 304", ras_din); end
      tick();
      drive(1'b1, 32'h310, enc_jalr(5'd1, 5'd1), 1'b0, 1'b0, 1'b0, 32'h0000_ABC0);
      @(negedge clk);
      n_cmp++; if (pred_valid !== 1'b1 || pred_target !== 32'h0000_ABC0 || pred_pc !== 32'h300) begin
         n_bad++; $display("FAIL co_pred: got v%b pc %h tgt %h want v1 pc 300 tgt abc0", pred_valid, pred_pc, pred_target); end
      // rd == rs1 == x1 is a call only
      n_cmp++; if ({ras_push, ras_pop} !== 2'b10) begin n_bad++; $display("FAIL same_link: got %b want 10", {ras_push, ras_pop}); end
      tick();
   endtask

   task automatic test_empty_pop();
      do_reset();
      drive(1'b1, 32'h400, enc_jalr(5'd0, 5'd5), 1'b0, 1'b0, 1'b1, '0);
      @(negedge clk);
      n_cmp++; if ({ras_push, ras_pop} !== 2'b00) begin n_bad++; $display("FAIL empty_pop: got %b want 00", {ras_push, ras_pop}); end
      tick();
      drive(1'b1, 32'h410, enc_jalr(5'd5, 5'd1), 1'b0, 1'b0, 1'b1, 32'h77);
      @(negedge clk);
      n_cmp++; if (pred_valid !== 1'b0) begin n_bad++; $display("FAIL empty_pred: got %b want 0", pred_valid); end
      n_cmp++; if ({ras_push, ras_pop} !== 2'b11) begin n_bad++; $display("FAIL empty_swap: got %b want 11", {ras_push, ras_pop}); end
      tick();
   endtask

   task automatic test_branch_limit();
      do_reset();
      for (int i = 0; i < 16; i++) begin
         drive(1'b1, 32'h1000 + 4 * i, enc_br(), 1'b0, 1'b0, 1'b0, '0);
         @(negedge clk);
         n_cmp++; if ({in_ready, ras_branch} !== 2'b11) begin
            n_bad++; $display("FAIL lim_accept%0d: got %b want 11", i, {in_ready, ras_branch}); end
         tick();
      end
      drive(1'b1, 32'h1040, enc_br(), 1'b0, 1'b0, 1'b0, '0);
      @(negedge clk);
      n_cmp++; if ({in_ready, ras_branch} !== 2'b00) begin n_bad++; $display("FAIL lim_full: got %b want 00", {in_ready, ras_branch}); end
      tick();
      drive(1'b1, 32'h1040, enc_br(), 1'b1, 1'b0, 1'b0, '0);
      @(negedge clk);
      n_cmp++; if ({in_ready, ras_branch, ras_close_valid} !== 3'b111) begin
         n_bad++; $display("FAIL lim_swap: got %b want 111", {in_ready, ras_branch, ras_close_valid}); end
      tick();
      drive(1'b1, 32'h1044, enc_br(), 1'b0, 1'b0, 1'b0, '0);
      @(negedge clk);
      n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL lim_still16: got %b want 0", in_ready); end
      tick();
      drive(1'b0, '0, 32'h13, 1'b1, 1'b0, 1'b0, '0);
      @(negedge clk);
      n_cmp++; if (ras_close_valid !== 1'b1) begin n_bad++; $display("FAIL lim_close: got %b want 1", ras_close_valid); end
      tick();
      drive(1'b1, 32'h1048, enc_br(), 1'b0, 1'b0, 1'b0, '0);
      @(negedge clk);
      n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL lim_room: got %b want 1", in_ready); end
      tick();
   endtask

   task automatic test_mispredict();
      do_reset();
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 32'h2000 + 4 * i, enc_br(), 1'b0, 1'b0, 1'b0, '0);
         tick();
      end
      drive(1'b1, 32'h500, enc_jal(5'd1), 1'b1, 1'b1, 1'b0, '0);
      @(negedge clk);
      n_cmp++; if ({ras_close_invalid, ras_push, in_ready} !== 3'b100) begin
         n_bad++; $display("FAIL mis_squash: got %b want 100", {ras_close_invalid, ras_push, in_ready}); end
      tick();
      // flush cycle: resolution is dropped without error
      drive(1'b1, 32'h500, enc_jal(5'd1), 1'b1, 1'b0, 1'b0, '0);
      @(negedge clk);
      n_cmp++; if ({in_ready, ras_push, ras_close_valid, ras_close_invalid} !== 4'b0000) begin
         n_bad++; $display("FAIL mis_flush: got %b want 0000", {in_ready, ras_push, ras_close_valid, ras_close_invalid}); end
      tick();
      drive(1'b1, 32'h500, enc_jal(5'd1), 1'b0, 1'b0, 1'b0, '0);
      @(negedge clk);
      n_cmp++; if ({in_ready, ras_push, err} !== 3'b110) begin
         n_bad++; $display("FAIL mis_resume: got %b want 110", {in_ready, ras_push, err}); end
      tick();
      drive(1'b0, '0, 32'h13, 1'b1, 1'b0, 1'b0, '0);
      @(negedge clk);
      n_cmp++; if (ras_close_valid !== 1'b0) begin n_bad++; $display("FAIL mis_cnt0: got %b want 0", ras_close_valid); end
      tick();
   endtask

   task automatic test_spurious_reset();
      do_reset();
      drive(1'b0, '0, 32'h13, 1'b1, 1'b0, 1'b0, '0);
      @(negedge clk);
      n_cmp++; if ({ras_close_valid, ras_close_invalid} !== 2'b00) begin
         n_bad++; $display("FAIL spur_close: got %b want 00", {ras_close_valid, ras_close_invalid}); end
      tick();
      drive(1'b1, 32'h600, enc_jalr(5'd0, 5'd1), 1'b0, 1'b0, 1'b0, '0);
      @(negedge clk);
      n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL spur_err: got %b want 1", err); end
      tick();
      drive(1'b0, '0, 32'h13, 1'b0, 1'b0, 1'b0, 32'h55);
      n_cmp++; if ({err, pred_valid} !== 2'b11) begin n_bad++; $display("FAIL spur_hold: got %b want 11", {err, pred_valid}); end
      #2;
      reset_n = 1'b0;
      #1;
      n_cmp++; if ({err, pred_valid, in_ready} !== 3'b001 || pred_pc !== '0) begin
         n_bad++; $display("FAIL async_rst: got %b pc %h want 001 pc 0", {err, pred_valid, in_ready}, pred_pc); end
      tick();
      reset_n = 1'b1;
   endtask

   task automatic test_random();
      int          m_cnt;
      bit          m_err, m_flush, m_pv;
      logic [W-1:0] m_ppc;
      logic [4:0]  regs [6];
      regs = '{5'd0, 5'd1, 5'd5, 5'd2, 5'd1, 5'd5};
      do_reset();
      m_cnt = 0; m_err = 0; m_flush = 0; m_pv = 0; m_ppc = '0;
      for (int cyc = 0; cyc < 2000; cyc++) begin
         int           kind;
         logic [4:0]   rd, rs1;
         logic [31:0]  ins;
         logic [W-1:0] pc, dout;
         bit           iv, rv, rm, emp, live, e_cv, e_ci, e_rdy, acc, wpush, wpop;
         bit           e_push, e_pop, e_br, lrd, lrs, isbr;
         logic [W-1:0] e_din, e_pt;
         kind = int'($urandom_range(0, 5));
         rd   = regs[$urandom_range(0, 5)];
         rs1  = regs[$urandom_range(0, 5)];
         case (kind)
            0:       ins = {$urandom_range(0, 32'hFFFFF), rd, 7'b1101111};
            1, 5:    ins = {12'($urandom), rs1, 3'b000, rd, 7'b1100111};
            2, 4:    ins = {25'($urandom), 7'b1100011};
            default: ins = {25'($urandom), 7'b0010011};
         endcase
         pc   = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
         dout = $urandom;
         iv   = ($urandom_range(0, 3) != 0);
         rv   = ($urandom_range(0, 4) == 0);
         rm   = rv && ($urandom_range(0, 5) == 0);
         emp  = ($urandom_range(0, 2) == 0);
         drive(iv, pc, ins, rv, rm, emp, dout);

         isbr  = (kind == 2 || kind == 4);
         lrd   = (rd == 5'd1 || rd == 5'd5);
         lrs   = (rs1 == 5'd1 || rs1 == 5'd5);
         wpush = (kind == 0 || kind == 1 || kind == 5) && lrd;
         wpop  = (kind == 1 || kind == 5) && lrs && (!lrd || rd != rs1);
         live  = !m_flush && rv;
         e_cv  = live && !rm && m_cnt > 0;
         e_ci  = live && rm && m_cnt > 0;
         e_rdy = !m_flush && !(rv && rm) && !(iv && isbr && m_cnt == 16 && !e_cv);
         acc   = iv && e_rdy;
         e_push = acc && wpush;
         e_pop  = acc && wpop && (!emp || e_push);
         e_br   = acc && isbr;
         e_din  = e_push ? pc + 32'd4 : '0;
         e_pt   = m_pv ? dout : '0;

         @(negedge clk);
         n_cmp++; if ({in_ready, ras_push, ras_pop, ras_branch, ras_close_valid, ras_close_invalid} !==
                      {e_rdy, e_push, e_pop, e_br, e_cv, e_ci}) begin
            n_bad++; $display("FAIL rnd_ctl c%0d: got %b want %b", cyc,
               {in_ready, ras_push, ras_pop, ras_branch, ras_close_valid, ras_close_invalid},
               {e_rdy, e_push, e_pop, e_br, e_cv, e_ci}); end
         n_cmp++; if (ras_din !== e_din) begin n_bad++; $display("FAIL rnd_din c%0d: got %h want %h", cyc, ras_din, e_din); end
         n_cmp++; if (pred_valid !== m_pv || pred_pc !== m_ppc || pred_target !== e_pt) begin
            n_bad++; $display("FAIL rnd_pred c%0d: got %b %h %h want %b %h %h", cyc,
                              pred_valid, pred_pc, pred_target, m_pv, m_ppc, e_pt); end
         n_cmp++; if (err !== m_err) begin n_bad++; $display("FAIL rnd_err c%0d: got %b want %b", cyc, err, m_err); end

         if (live && m_cnt == 0) m_err = 1;
         if (e_ci) m_cnt = 0;
         else m_cnt = m_cnt + int'(e_br) - int'(e_cv);
         m_flush = e_ci;
         m_pv = e_pop;
         if (e_pop) m_ppc = pc;
         tick();
      end
   endtask

   initial begin
      test_reset();
      test_call_return();
      test_coroutine();
      test_empty_pop();
      test_branch_limit();
      test_mispredict();
      test_spurious_reset();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
